// File: rtl/router_vc_pkg.sv
// Shared definitions for the VC output port: arbitration modes and
// channel/credit field positions as functions of the port widths.
package router_vc_pkg;

  localparam logic [1:0] MODE_ASC  = 2'b00;
  localparam logic [1:0] MODE_DESC = 2'b01;
  localparam logic [1:0] MODE_RR   = 2'b10;

  function automatic int vc_width(int num_vcs);
    return (num_vcs <= 1) ? 1 : $clog2(num_vcs);
  endfunction

  // Channel layout, MSB to LSB: valid, head, tail, vc, payload
  function automatic int ch_vld_pos(int vc_w, int flit_w);
    return flit_w + vc_w + 2;
  endfunction

  function automatic int ch_vc_lsb(int flit_w);
    return flit_w;
  endfunction

  // Credit layout, MSB to LSB: valid, vc
  function automatic int cr_vld_pos(int vc_w);
    return vc_w;
  endfunction

endpackage

// File: rtl/router_vc_fifo.sv
// Single-VC synchronous FIFO; pointers carry an extra MSB for wrap detection.
module router_vc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][W-1:0]    mem_q, mem_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d  = wr_q + (AW+1)'(push);
    rd_d  = rd_q + (AW+1)'(pop);
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/router_vc_port.sv
// Virtual-channel output port: per-VC buffering, downstream credit tracking
// and a one-flit-per-cycle arbiter feeding a registered output channel.
module router_vc_port import router_vc_pkg::*; #(
  parameter  int         NUM_VCS      = 2,
  parameter  int         FLIT_WIDTH   = 32,
  parameter  int         BUF_DEPTH    = 4,
  parameter  int         DOWN_CREDITS = 4,
  parameter  logic [1:0] MODE         = 2'b00,
  localparam int         VC_W         = vc_width(NUM_VCS),
  localparam int         CH_W         = 3 + VC_W + FLIT_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH_W-1:0] channel_in_ip,
  output logic [VC_W:0]   flow_ctrl_out_ip,
  output logic [CH_W-1:0] channel_out_op,
  input  logic [VC_W:0]   flow_ctrl_in_op,
  output logic            error
);
  localparam int CR_W = $clog2(DOWN_CREDITS + 1);
  localparam int DW   = CH_W - 1;

  logic            in_vld, in_vc_ok, fc_vld, fc_vc_ok;
  logic [VC_W-1:0] in_vc, fc_vc;
  logic [DW-1:0]   in_data;

  assign in_vld   = channel_in_ip[ch_vld_pos(VC_W, FLIT_WIDTH)];
  assign in_vc    = channel_in_ip[ch_vc_lsb(FLIT_WIDTH) +: VC_W];
  assign in_data  = channel_in_ip[DW-1:0];
  assign fc_vld   = flow_ctrl_in_op[cr_vld_pos(VC_W)];
  assign fc_vc    = flow_ctrl_in_op[VC_W-1:0];
  assign in_vc_ok = ({1'b0, in_vc} < (VC_W+1)'(NUM_VCS));
  assign fc_vc_ok = ({1'b0, fc_vc} < (VC_W+1)'(NUM_VCS));

  logic [NUM_VCS-1:0]           push, pop, full, empty, elig;
  logic [NUM_VCS-1:0][DW-1:0]   head;
  logic [NUM_VCS-1:0][CR_W-1:0] credit_q, credit_d;
  logic [VC_W-1:0]              last_q, last_d, gnt_vc;
  logic                         gnt_any, in_err, cr_err;
  logic [CH_W-1:0]              ch_out_q, ch_out_d;
  logic [VC_W:0]                fc_out_q, fc_out_d;
  logic                         err_q, err_d;
  int                           idx;

  for (genvar g = 0; g < NUM_VCS; g++) begin : g_vc
    router_vc_fifo #(.W(DW), .DEPTH(BUF_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (in_data),
      .full  (full[g]),
      .empty (empty[g]),
      .dout  (head[g])
    );
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_vc  = '0;
    idx     = 0;
    for (int v = 0; v < NUM_VCS; v++) elig[v] = !empty[v] && (credit_q[v] != '0);
    case (MODE)
      MODE_DESC: begin
        for (int v = 0; v < NUM_VCS; v++)
          if (elig[v]) begin gnt_any = 1'b1; gnt_vc = VC_W'(v); end
      end
      MODE_RR: begin
        // Walk from farthest to nearest so the VC right after last_grant wins
        for (int k = NUM_VCS; k >= 1; k--) begin
          idx = (int'(last_q) + k) % NUM_VCS;
          if (elig[idx]) begin gnt_any = 1'b1; gnt_vc = VC_W'(idx); end
        end
      end
      default: begin
        for (int v = NUM_VCS - 1; v >= 0; v--)
          if (elig[v]) begin gnt_any = 1'b1; gnt_vc = VC_W'(v); end
      end
    endcase
  end

  // Pop is decided before push, so a full FIFO being drained still accepts
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      pop[v]  = gnt_any && (gnt_vc == VC_W'(v));
      push[v] = in_vld && in_vc_ok && (in_vc == VC_W'(v)) && (!full[v] || pop[v]);
    end
    in_err = in_vld && !(|push);
  end

  always_comb begin
    credit_d = credit_q;
    cr_err   = fc_vld && !fc_vc_ok;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (fc_vld && fc_vc_ok && (fc_vc == VC_W'(v)) && !pop[v]) begin
        if (credit_q[v] == CR_W'(DOWN_CREDITS)) cr_err = 1'b1;
        else credit_d[v] = credit_q[v] + CR_W'(1);
      end else if (pop[v] && !(fc_vld && fc_vc_ok && (fc_vc == VC_W'(v)))) begin
        credit_d[v] = credit_q[v] - CR_W'(1);
      end
    end
  end

  always_comb begin
    last_d   = gnt_any ? gnt_vc : last_q;
    ch_out_d = gnt_any ? {1'b1, head[gnt_vc]} : '0;
    fc_out_d = gnt_any ? {1'b1, gnt_vc} : '0;
    err_d    = err_q | in_err | cr_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_q <= {NUM_VCS{CR_W'(DOWN_CREDITS)}};
      last_q   <= VC_W'(NUM_VCS - 1);
      ch_out_q <= '0;
      fc_out_q <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      last_q   <= last_d;
      ch_out_q <= ch_out_d;
      fc_out_q <= fc_out_d;
      err_q    <= err_d;
    end
  end

  assign channel_out_op   = ch_out_q;
  assign flow_ctrl_out_ip = fc_out_q;
  assign error            = err_q;

endmodule

// File: tb/tb_router_vc_port.sv
// Directed bench for router_vc_port: three instances (ascending, descending,
// round-robin) share the same stimulus; each scenario checks its own outputs.
module tb_router_vc_port;
  localparam int CH_W = 36;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [CH_W-1:0] ch_in = '0;
  logic [1:0]      fc_in = '0;
  logic [CH_W-1:0] ch_out0, ch_out1, ch_out2;
  logic [1:0]      fc_out0, fc_out1, fc_out2;
  logic            err0, err1, err2;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  router_vc_port #(.MODE(2'b00)) dut0 (.clk(clk), .reset(reset), .channel_in_ip(ch_in),
    .flow_ctrl_out_ip(fc_out0), .channel_out_op(ch_out0), .flow_ctrl_in_op(fc_in), .error(err0));
  router_vc_port #(.MODE(2'b01)) dut1 (.clk(clk), .reset(reset), .channel_in_ip(ch_in),
    .flow_ctrl_out_ip(fc_out1), .channel_out_op(ch_out1), .flow_ctrl_in_op(fc_in), .error(err1));
  router_vc_port #(.MODE(2'b10)) dut2 (.clk(clk), .reset(reset), .channel_in_ip(ch_in),
    .flow_ctrl_out_ip(fc_out2), .channel_out_op(ch_out2), .flow_ctrl_in_op(fc_in), .error(err2));

  function automatic logic [CH_W-1:0] mk(input logic vc, input logic [31:0] pay);
    return {1'b1, 1'b1, 1'b1, vc, pay};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    ch_in = '0; fc_in = '0; reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    ch_in = mk(1'b0, 32'h5A); reset = 1'b0;
    #3;
    checks++; if (ch_out0 !== '0) begin errors++; $display("FAIL reset_ch_out got %h exp 0", ch_out0); end
    checks++; if (fc_out0 !== '0) begin errors++; $display("FAIL reset_fc_out got %h exp 0", fc_out0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", err0); end
    tick(); tick();
    checks++; if ({ch_out1, ch_out2, err1, err2} !== '0) begin errors++;
      $display("FAIL reset_others got %h %h %b %b exp 0", ch_out1, ch_out2, err1, err2); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    ch_in = mk(1'b0, 32'hA5);
    tick(); ch_in = '0;
    checks++; if (ch_out0[CH_W-1] !== 1'b0) begin errors++; $display("FAIL basic_t1 got %h exp invalid", ch_out0); end
    tick();
    checks++; if (ch_out0 !== mk(1'b0, 32'hA5)) begin errors++; $display("FAIL basic_t2 got %h exp %h", ch_out0, mk(1'b0, 32'hA5)); end
    checks++; if (fc_out0 !== 2'b10) begin errors++; $display("FAIL basic_credit got %b exp 10", fc_out0); end
    tick();
    checks++; if ({ch_out0[CH_W-1], fc_out0[1]} !== 2'b00) begin errors++;
      $display("FAIL basic_pulse got %b%b exp 00", ch_out0[CH_W-1], fc_out0[1]); end
  endtask

  task automatic test_credit_exhaust();
    int cnt = 0;
    logic [31:0] last_pay = '0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ch_in = mk(1'b1, 32'(i + 1)); tick();
      if (ch_out0[CH_W-1]) begin cnt++; last_pay = ch_out0[31:0]; end
    end
    ch_in = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ch_out0[CH_W-1]) begin cnt++; last_pay = ch_out0[31:0]; end
    end
    checks++; if (cnt != 4) begin errors++; $display("FAIL exhaust_count got %0d exp 4", cnt); end
    checks++; if (last_pay !== 32'd4) begin errors++; $display("FAIL exhaust_last got %0d exp 4", last_pay); end
    fc_in = 2'b11; tick(); fc_in = '0;
    checks++; if (ch_out0[CH_W-1] !== 1'b0) begin errors++; $display("FAIL exhaust_early got %h exp invalid", ch_out0); end
    tick();
    checks++; if (ch_out0 !== mk(1'b1, 32'd5)) begin errors++; $display("FAIL exhaust_fifth got %h exp %h", ch_out0, mk(1'b1, 32'd5)); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL exhaust_error got %b exp 0", err0); end
  endtask

  // VC0 holds a flit with no credit; its credit and a VC1 flit arrive together
  task automatic test_arb_fixed();
    do_reset();
    for (int i = 0; i < 5; i++) begin ch_in = mk(1'b0, 32'(i + 1)); tick(); end
    ch_in = '0;
    repeat (4) tick();
    ch_in = mk(1'b1, 32'h11); fc_in = 2'b10; tick();
    ch_in = '0; fc_in = '0;
    tick();
    checks++; if (ch_out0 !== mk(1'b0, 32'd5)) begin errors++; $display("FAIL asc_first got %h exp %h", ch_out0, mk(1'b0, 32'd5)); end
    checks++; if (ch_out1 !== mk(1'b1, 32'h11)) begin errors++; $display("FAIL desc_first got %h exp %h", ch_out1, mk(1'b1, 32'h11)); end
    tick();
    checks++; if (ch_out0 !== mk(1'b1, 32'h11)) begin errors++; $display("FAIL asc_second got %h exp %h", ch_out0, mk(1'b1, 32'h11)); end
    checks++; if (ch_out1 !== mk(1'b0, 32'd5)) begin errors++; $display("FAIL desc_second got %h exp %h", ch_out1, mk(1'b0, 32'd5)); end
  endtask

  // VC0 backlog waits on credits while VC1 flits and VC0 credits stream in
  task automatic test_rr();
    logic seq [8];
    int n = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin ch_in = mk(1'b0, 32'(i)); tick(); end
    ch_in = '0;
    repeat (3) tick();
    for (int k = 0; k < 12; k++) begin
      if (k < 4) begin ch_in = mk(1'b1, 32'(k)); fc_in = 2'b10; end
      else begin ch_in = '0; fc_in = '0; end
      tick();
      if (ch_out2[CH_W-1]) begin
        if (n < 8) seq[n] = ch_out2[32];
        n++;
      end
    end
    checks++; if (n != 8) begin errors++; $display("FAIL rr_count got %0d exp 8", n); end
    for (int j = 0; j < 8 && j < n; j++) begin
      checks++; if (seq[j] !== ((j % 2 == 0) ? 1'b1 : 1'b0)) begin errors++;
        $display("FAIL rr_order idx %0d got %b exp %b", j, seq[j], (j % 2 == 0) ? 1'b1 : 1'b0); end
    end
  endtask

  task automatic test_overflow();
    int cnt = 0;
    logic [31:0] last_pay = '0;
    do_reset();
    for (int i = 0; i < 4; i++) begin ch_in = mk(1'b0, 32'(i + 1)); tick(); end
    ch_in = '0;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin ch_in = mk(1'b0, 32'h21 + 32'(i)); tick(); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL ovf_before got %b exp 0", err0); end
    ch_in = mk(1'b0, 32'h25); tick(); ch_in = '0;
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", err0); end
    repeat (2) tick();
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", err0); end
    for (int i = 0; i < 10; i++) begin
      fc_in = (i < 4) ? 2'b10 : 2'b00;
      tick();
      if (ch_out0[CH_W-1]) begin cnt++; last_pay = ch_out0[31:0]; end
    end
    fc_in = '0;
    checks++; if (cnt != 4) begin errors++; $display("FAIL ovf_count got %0d exp 4", cnt); end
    checks++; if (last_pay !== 32'h24) begin errors++; $display("FAIL ovf_last got %h exp 24", last_pay); end
    do_reset();
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b exp 0", err0); end
  endtask

  task automatic test_credit_overflow();
    int cnt = 0;
    do_reset();
    fc_in = 2'b10; tick(); fc_in = '0;
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL crovf_error got %b exp 1", err0); end
    for (int i = 0; i < 11; i++) begin
      ch_in = (i < 5) ? mk(1'b0, 32'(i)) : '0;
      tick();
      if (ch_out0[CH_W-1]) cnt++;
    end
    ch_in = '0;
    checks++; if (cnt != 4) begin errors++; $display("FAIL crovf_saturate got %0d exp 4", cnt); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 3; i++) begin ch_in = mk(1'b1, 32'(i)); tick(); end
    ch_in = '0;
    repeat (3) tick();
    ch_in = mk(1'b1, 32'h31); tick();
    ch_in = mk(1'b1, 32'h32); fc_in = 2'b11; tick();
    ch_in = '0; fc_in = '0;
    checks++; if (ch_out0 !== mk(1'b1, 32'h31)) begin errors++; $display("FAIL same_first got %h exp %h", ch_out0, mk(1'b1, 32'h31)); end
    checks++; if (fc_out0 !== 2'b11) begin errors++; $display("FAIL same_credit got %b exp 11", fc_out0); end
    tick();
    checks++; if (ch_out0 !== mk(1'b1, 32'h32)) begin errors++; $display("FAIL same_next got %h exp %h", ch_out0, mk(1'b1, 32'h32)); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL same_error got %b exp 0", err0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_exhaust();
    test_arb_fixed();
    test_rr();
    test_overflow();
    test_credit_overflow();
    test_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
